// File: rtl/pulse_pacer_pkg.sv
// Shared state encodings, output-mode constants and the gap-counter sizing helper.
package pulse_pacer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int MODE_PULSE  = 0;
    localparam int MODE_TOGGLE = 1;

    // The gap counter is loaded with GAP-1, so it needs clog2(GAP) bits, never fewer than 1.
    function automatic int gap_cnt_w(input int gap);
        return (gap <= 1) ? 1 : $clog2(gap);
    endfunction

endpackage

// File: rtl/pulse_pacer_ch.sv
// One pacer channel: pending-event counter, IDLE/EMIT/GAP sequencer, sticky overflow.
// All outputs registered; the pending counter saturates and drops events rather than back-pressuring.
module pulse_pacer_ch
    import pulse_pacer_pkg::*;
#(
    parameter int CNTW = 4,
    parameter int GAP  = 2,
    parameter int MODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pulse_i,
    input  logic            ovf_clr_i,
    output logic            pulse_o,
    output logic            busy_o,
    output logic            ovf_o,
    output logic [CNTW-1:0] cnt_o
);

    localparam int              GW       = gap_cnt_w(GAP);
    localparam logic [GW-1:0]   GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [GW-1:0]   GAP_ONE  = GW'(1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            out_q, busy_q, ovf_q;
    logic            idle_rules, drop;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        drop       = 1'b0;
        // IDLE decision also applies on the last GAP cycle, and every EMIT cycle when there is no gap.
        idle_rules = (state_q == ST_IDLE) ||
                     ((state_q == ST_EMIT) && (GAP == 0)) ||
                     ((state_q == ST_GAP) && (gap_q == '0));
        if (idle_rules) begin
            if ((cnt_q != '0) || pulse_i) begin
                state_d = ST_EMIT;
                if (!pulse_i) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            if (state_q == ST_EMIT) begin
                state_d = ST_GAP;
                gap_d   = GAP_LOAD;
            end else begin
                gap_d   = gap_q - GAP_ONE;
            end
            if (pulse_i) begin
                if (cnt_q == CNT_MAX) begin
                    drop = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            busy_q  <= (state_d != ST_IDLE) || (cnt_d != '0);
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_q <= 1'b0;
            end
            if (MODE == MODE_PULSE) begin
                out_q <= (state_d == ST_EMIT);
            end else begin
                out_q <= out_q ^ (state_d == ST_EMIT);
            end
        end
    end

    assign pulse_o = out_q;
    assign busy_o  = busy_q;
    assign ovf_o   = ovf_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/pulse_pacer.sv
// Multi-channel pulse pacer: NCH independent channels, each re-emitting events at least GAP+1 cycles apart.
// Latency 1 cycle from an event on an idle channel; no backpressure, excess events beyond the counter are dropped and flagged.
module pulse_pacer
    import pulse_pacer_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int CNTW = 4,
    parameter int GAP  = 2,
    parameter int MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      pulse_in,
    input  logic [NCH-1:0]      ovf_clr,
    output logic [NCH-1:0]      pulse_out,
    output logic [NCH-1:0]      busy,
    output logic [NCH-1:0]      ovf,
    output logic [NCH*CNTW-1:0] pend_cnt
);

    if ((NCH < 1) || (NCH > 32) || (CNTW < 1) || (GAP < 0) || (GAP > 255) ||
        ((MODE != MODE_PULSE) && (MODE != MODE_TOGGLE))) begin : g_bad_params
        $error("pulse_pacer: illegal parameters NCH=%0d CNTW=%0d GAP=%0d MODE=%0d", NCH, CNTW, GAP, MODE);
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pulse_pacer_ch #(
            .CNTW (CNTW),
            .GAP  (GAP),
            .MODE (MODE)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .pulse_i   (pulse_in[i]),
            .ovf_clr_i (ovf_clr[i]),
            .pulse_o   (pulse_out[i]),
            .busy_o    (busy[i]),
            .ovf_o     (ovf[i]),
            .cnt_o     (pend_cnt[i*CNTW +: CNTW])
        );
    end

endmodule

// File: tb/tb_pulse_pacer.sv
// Directed bench: four pacer configurations (GAP=2, saturating CNTW=2/GAP=3, GAP=0, toggle mode) on one clock.
module tb_pulse_pacer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // a: NCH=4 CNTW=4 GAP=2 pulse ; s: CNTW=2 GAP=3 ; z: GAP=0 ; t: GAP=2 toggle
    logic [3:0]  a_pin = '0, a_clr = '0, a_pout, a_busy, a_ovf;
    logic [15:0] a_pend;
    logic [3:0]  s_pin = '0, s_clr = '0, s_pout, s_busy, s_ovf;
    logic [7:0]  s_pend;
    logic [3:0]  z_pin = '0, z_clr = '0, z_pout, z_busy, z_ovf;
    logic [15:0] z_pend;
    logic [3:0]  t_pin = '0, t_clr = '0, t_pout, t_busy, t_ovf;
    logic [15:0] t_pend;

    pulse_pacer #(.NCH(4), .CNTW(4), .GAP(2), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .pulse_in(a_pin), .ovf_clr(a_clr),
        .pulse_out(a_pout), .busy(a_busy), .ovf(a_ovf), .pend_cnt(a_pend));
    pulse_pacer #(.NCH(4), .CNTW(2), .GAP(3), .MODE(0)) u_s (
        .clk(clk), .rst(rst), .pulse_in(s_pin), .ovf_clr(s_clr),
        .pulse_out(s_pout), .busy(s_busy), .ovf(s_ovf), .pend_cnt(s_pend));
    pulse_pacer #(.NCH(4), .CNTW(4), .GAP(0), .MODE(0)) u_z (
        .clk(clk), .rst(rst), .pulse_in(z_pin), .ovf_clr(z_clr),
        .pulse_out(z_pout), .busy(z_busy), .ovf(z_ovf), .pend_cnt(z_pend));
    pulse_pacer #(.NCH(4), .CNTW(4), .GAP(2), .MODE(1)) u_t (
        .clk(clk), .rst(rst), .pulse_in(t_pin), .ovf_clr(t_clr),
        .pulse_out(t_pout), .busy(t_busy), .ovf(t_ovf), .pend_cnt(t_pend));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int emits;
        int budget;
        logic [3:0] burst_pend [16] = '{0,1,2,2,3,3,2,2,2,1,1,1,0,0,0,0};
        logic [1:0] sat_pend [21]   = '{0,1,2,3,3,3,3,3,2,2,2,2,1,1,1,1,0,0,0,0,0};
        logic       tog;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_a_pout", a_pout, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_ovf",  a_ovf,  0);
        chk("rst_a_pend", a_pend, 0);
        chk("rst_s_pend", s_pend, 0);
        chk("rst_t_pout", t_pout, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_quiet", {a_pout, s_pout, z_pout, t_pout}, 0);

        // Single event on channel 1: one pulse, busy for 3 cycles
        a_pin = 4'b0010;
        tick();
        a_pin = '0;
        chk("single_pout0", a_pout, 4'b0010);
        chk("single_busy0", a_busy, 4'b0010);
        chk("single_pend0", a_pend, 0);
        tick();
        chk("single_pout1", a_pout, 0);
        chk("single_busy1", a_busy, 4'b0010);
        tick();
        chk("single_busy2", a_busy, 4'b0010);
        tick();
        chk("single_busy3", a_busy, 0);
        chk("single_pend3", a_pend, 0);

        // Burst of 5 on channel 0, GAP=2: emissions every 3 cycles
        emits = 0;
        for (int e = 0; e < 16; e++) begin
            a_pin = (e < 5) ? 4'b0001 : 4'b0000;
            tick();
            if (a_pout[0]) emits++;
            chk($sformatf("burst_pout_e%0d", e), a_pout, ((e % 3 == 0) && (e <= 12)) ? 4'b0001 : 4'b0000);
            chk($sformatf("burst_pend_e%0d", e), a_pend, {12'd0, burst_pend[e]});
            chk($sformatf("burst_busy_e%0d", e), a_busy[0], (e < 15) ? 1'b1 : 1'b0);
        end
        a_pin = '0;
        chk("burst_emits", emits, 5);
        chk("burst_ovf", a_ovf, 0);

        // Saturation on channel 2: CNTW=2, GAP=3, 8 events -> 5 emitted, 3 dropped
        emits = 0;
        for (int e = 0; e < 21; e++) begin
            s_pin = (e < 8) ? 4'b0100 : 4'b0000;
            tick();
            if (s_pout[2]) emits++;
            chk($sformatf("sat_pout_e%0d", e), s_pout, ((e % 4 == 0) && (e <= 16)) ? 4'b0100 : 4'b0000);
            chk($sformatf("sat_pend_e%0d", e), s_pend[5:4], sat_pend[e]);
            chk($sformatf("sat_ovf_e%0d", e), s_ovf, (e >= 5) ? 4'b0100 : 4'b0000);
        end
        s_pin = '0;
        chk("sat_emits", emits, 5);
        chk("sat_busy_end", s_busy, 0);
        s_clr = 4'b0100;
        tick();
        s_clr = '0;
        chk("sat_ovf_clr", s_ovf, 0);

        // Clear coinciding with a drop: set wins
        s_pin = 4'b0100;
        for (int e = 0; e < 5; e++) tick();
        chk("coin_pre_ovf", s_ovf, 0);
        chk("coin_pre_pend", s_pend[5:4], 2'd3);
        s_clr = 4'b0100;
        tick();
        s_clr = '0;
        s_pin = '0;
        chk("coin_ovf_set_wins", s_ovf, 4'b0100);
        budget = 0;
        while ((s_busy != 0) && (budget < 40)) begin
            tick();
            budget++;
        end
        chk("coin_drain", s_busy, 0);
        s_clr = 4'b0100;
        tick();
        s_clr = '0;
        chk("coin_ovf_cleared", s_ovf, 0);

        // GAP=0: continuous input emits back-to-back, never accumulates
        for (int e = 0; e < 8; e++) begin
            z_pin = (e < 6) ? 4'b0001 : 4'b0000;
            tick();
            chk($sformatf("gap0_pout_e%0d", e), z_pout, (e < 6) ? 4'b0001 : 4'b0000);
            chk($sformatf("gap0_pend_e%0d", e), z_pend, 0);
        end
        z_pin = '0;
        chk("gap0_ovf", z_ovf, 0);
        chk("gap0_busy", z_busy, 0);

        // Toggle mode: three spaced events flip the level once each
        tog = 1'b0;
        chk("tog_init", t_pout, 0);
        for (int ev = 0; ev < 3; ev++) begin
            t_pin = 4'b0001;
            tick();
            t_pin = '0;
            tog = ~tog;
            chk($sformatf("tog_ev%0d", ev), t_pout[0], tog);
            for (int w = 0; w < 4; w++) tick();
            chk($sformatf("tog_hold%0d", ev), t_pout[0], tog);
        end
        chk("tog_others", t_pout[3:1], 0);

        // Reset mid-burst discards pending events and clears the level
        t_pin = 4'b0001;
        for (int e = 0; e < 4; e++) tick();
        t_pin = '0;
        chk("tog_burst_pout", t_pout[0], 1'b1);
        chk("tog_burst_pend", t_pend, 16'd2);
        rst = 1'b1;
        tick();
        chk("mid_rst_pout", t_pout, 0);
        chk("mid_rst_pend", t_pend, 0);
        chk("mid_rst_busy", t_busy, 0);
        rst = 1'b0;
        tick();
        chk("after_rst_no_emit", t_pout, 0);
        chk("after_rst_pend", t_pend, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
